axi_lite_master_bridge: RTL
===========================

// Module: axi_lite_master_bridge
// PURPOSE
//  AXI4-Lite initiator. Turns single-beat register commands from local logic (sequencers, self-test) into
//  AXI4-Lite reads/writes toward the slave-side register bridges in the design. One transaction in flight at a time.
//  Word-addressed command side; byte-addressed AXI side.
// PARAMETERS
//  ADDR_WIDTH        14    command word-address width; AXI byte address = {cmd_addr,2'b00} zero-extended
//  DATA_WIDTH        16    command data width; zero-extended on write, low bits taken on read
//  M_AXI_ADDR_WIDTH  32    AXI address width (>= ADDR_WIDTH+2)
//  M_AXI_DATA_WIDTH  32    AXI data width (>= DATA_WIDTH)
//  TIMEOUT_CYCLES    1024  watchdog limit in clocks (used only with AXI_TIMEOUT_EN)
// PORTS
//  M_AXI_aclk     in   1   single clock
//  M_AXI_areset   in   1   asynchronous, active-high reset
//  cmd_valid      in   1   command request
//  cmd_ready      out  1   high in IDLE only
//  cmd_write      in   1   1=write, 0=read
//  cmd_addr       in   ADDR_WIDTH   word address
//  cmd_wdata      in   DATA_WIDTH   write data
//  rsp_valid      out  1   one-cycle completion pulse
//  rsp_rdata      out  DATA_WIDTH   read data (0 for writes)
//  rsp_resp       out  2   BRESP/RRESP, or 2'b10 on timeout
//  timeout        out  1   one-cycle pulse with a timed-out rsp_valid (constant 0 without macro)
//  M_AXI_awaddr/awprot/awvalid out M_AXI_ADDR_WIDTH/3/1; M_AXI_awready in 1
//  M_AXI_wdata/wstrb/wvalid    out M_AXI_DATA_WIDTH/M_AXI_DATA_WIDTH/8/1; M_AXI_wready in 1
//  M_AXI_bresp in 2; M_AXI_bvalid in 1; M_AXI_bready out 1
//  M_AXI_araddr/arprot/arvalid out M_AXI_ADDR_WIDTH/3/1; M_AXI_arready in 1
//  M_AXI_rdata in M_AXI_DATA_WIDTH; M_AXI_rresp in 2; M_AXI_rvalid in 1; M_AXI_rready out 1
// BEHAVIOUR
//  - Reset: all outputs 0 (awaddr/araddr/wdata/rsp_* = 0); state IDLE; cmd_ready=1 after release. Reset mid-transaction
//    drops all valids immediately, discards the transaction, no rsp_valid.
//  - FSM: IDLE -> WR_AW_W -> WR_B -> IDLE ; IDLE -> RD_AR -> RD_R -> IDLE. All AXI outputs registered.
//  - Accept at edge N when cmd_valid&cmd_ready; addr/data registered; valids high from cycle N+1.
//  - WR_AW_W: awvalid and wvalid both high; each drops on own handshake (independent; either order or same cycle).
//    Both done -> WR_B with bready=1. wstrb all ones, awprot/arprot=3'b000.
//  - WR_B: on bvalid -> bready=0, rsp_valid pulse next cycle, rsp_resp=bresp, rsp_rdata=0, back to IDLE.
//  - RD_AR: arvalid high until arready -> RD_R, rready=1. On rvalid: capture rdata[DATA_WIDTH-1:0], rresp;
//    rready=0, rsp_valid pulse next cycle.
//  - Valids never drop before handshake (except timeout/reset); address/data stable while valid.
//  - Zero-wait slave: write accept N -> handshake N+1 -> bvalid >= N+2 -> rsp_valid one cycle after B handshake.
//  - cmd_ready low from acceptance until the cycle after rsp_valid (IDLE); back-to-back cmds have 1-cycle gap min.
//  - bvalid/rvalid arriving while not in WR_B/RD_R: ignored (ready low).
// CONFIGURATION
//  AXI_TIMEOUT_EN defined: counter clears on accept, counts every non-IDLE cycle; reaching TIMEOUT_CYCLES
//    drops all AXI valids/readies, emits rsp_valid with rsp_resp=2'b10, rsp_rdata=0, timeout=1, returns to IDLE
//    (debug recovery; a late slave response is ignored). Completion in the same cycle as expiry wins (normal rsp).
//  Not defined: no counter; waits indefinitely; timeout tied 0.
// STRUCTURE
//  Package axi_lite_pkg: RESP_OKAY/EXOKAY/SLVERR/DECERR constants, state enum type, PROT_DEFAULT.
//  Single module; no sub-module (watchdog inline under the macro).
// TESTING
//  1. Write addr 0x0005 data 0xBEEF, slave ready always -> awaddr=0x14, wdata=0x0000BEEF, wstrb=4'hF; rsp_resp=00.
//  2. Write with awready 3 cycles before wready -> awvalid drops first, wvalid holds; exactly one rsp_valid.
//  3. Read addr 0x3FFF, rdata=0xCAFE1234, rresp=00 after 4 wait cycles -> araddr=0xFFFC, rsp_rdata=0x1234.
//  4. Write bresp=2'b10 -> rsp_resp=2'b10; next cmd accepted cmd_ready back one cycle after rsp_valid.
//  5. AXI_TIMEOUT_EN, TIMEOUT_CYCLES=16, arready never -> rsp_valid+timeout at 16 cycles, resp 10, arvalid low.
//  6. Assert reset in WR_B -> bready/valids low same cycle, no rsp_valid; fresh read after release completes.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared constants and state type for the AXI4-Lite master bridge.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_AW_W,
    ST_WR_B,
    ST_RD_AR,
    ST_RD_R
  } state_t;

endpackage

// File: rtl/axi_lite_master_bridge.sv
// Single-outstanding AXI4-Lite initiator: word-addressed command port in, byte-addressed AXI out.
// Optional watchdog enabled by defining AXI_TIMEOUT_EN.
module axi_lite_master_bridge
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH       = 14,
  parameter int DATA_WIDTH       = 16,
  parameter int M_AXI_ADDR_WIDTH = 32,
  parameter int M_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                          M_AXI_aclk,
  input  logic                          M_AXI_areset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [ADDR_WIDTH-1:0]         cmd_addr,
  input  logic [DATA_WIDTH-1:0]         cmd_wdata,
  output logic                          rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          timeout,
  output logic [M_AXI_ADDR_WIDTH-1:0]   M_AXI_awaddr,
  output logic [2:0]                    M_AXI_awprot,
  output logic                          M_AXI_awvalid,
  input  logic                          M_AXI_awready,
  output logic [M_AXI_DATA_WIDTH-1:0]   M_AXI_wdata,
  output logic [M_AXI_DATA_WIDTH/8-1:0] M_AXI_wstrb,
  output logic                          M_AXI_wvalid,
  input  logic                          M_AXI_wready,
  input  logic [1:0]                    M_AXI_bresp,
  input  logic                          M_AXI_bvalid,
  output logic                          M_AXI_bready,
  output logic [M_AXI_ADDR_WIDTH-1:0]   M_AXI_araddr,
  output logic [2:0]                    M_AXI_arprot,
  output logic                          M_AXI_arvalid,
  input  logic                          M_AXI_arready,
  input  logic [M_AXI_DATA_WIDTH-1:0]   M_AXI_rdata,
  input  logic [1:0]                    M_AXI_rresp,
  input  logic                          M_AXI_rvalid,
  output logic                          M_AXI_rready
);

  state_t                        r_state;
  logic                          r_cmd_ready;
  logic                          r_rsp_valid;
  logic [DATA_WIDTH-1:0]         r_rsp_rdata;
  logic [1:0]                    r_rsp_resp;
  logic [M_AXI_ADDR_WIDTH-1:0]   r_awaddr;
  logic [M_AXI_ADDR_WIDTH-1:0]   r_araddr;
  logic [M_AXI_DATA_WIDTH-1:0]   r_wdata;
  logic [M_AXI_DATA_WIDTH/8-1:0] r_wstrb;
  logic                          r_awvalid;
  logic                          r_wvalid;
  logic                          r_bready;
  logic                          r_arvalid;
  logic                          r_rready;

  logic [M_AXI_ADDR_WIDTH-1:0]   w_byte_addr;
  logic [M_AXI_DATA_WIDTH-1:0]   w_wdata_ext;
  logic                          w_aw_done;
  logic                          w_w_done;
  logic                          w_complete;
  logic                          w_unused;

  assign w_byte_addr = M_AXI_ADDR_WIDTH'({cmd_addr, 2'b00});
  assign w_wdata_ext = M_AXI_DATA_WIDTH'(cmd_wdata);
  // A channel counts as done if it already handshook or is handshaking this cycle.
  assign w_aw_done   = !r_awvalid || M_AXI_awready;
  assign w_w_done    = !r_wvalid  || M_AXI_wready;
  assign w_complete  = (r_state == ST_WR_B && M_AXI_bvalid) || (r_state == ST_RD_R && M_AXI_rvalid);
  assign w_unused    = &{1'b0, M_AXI_rdata, (TIMEOUT_CYCLES > 0)};

`ifdef AXI_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;
  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge M_AXI_aclk or posedge M_AXI_areset) begin
    if (M_AXI_areset) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
      r_awaddr    <= '0;
      r_araddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
`ifdef AXI_TIMEOUT_EN
      r_cnt       <= '0;
      r_timeout   <= 1'b0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            if (cmd_write) begin
              r_awaddr  <= w_byte_addr;
              r_wdata   <= w_wdata_ext;
              r_wstrb   <= '1;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= ST_WR_AW_W;
            end else begin
              r_araddr  <= w_byte_addr;
              r_arvalid <= 1'b1;
              r_state   <= ST_RD_AR;
            end
          end else begin
            // Holding off one cycle after rsp_valid falls out naturally: ready rises at this edge.
            r_cmd_ready <= 1'b1;
          end
        end
        ST_WR_AW_W: begin
          if (M_AXI_awready) r_awvalid <= 1'b0;
          if (M_AXI_wready)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= ST_WR_B;
          end
        end
        ST_WR_B: begin
          if (M_AXI_bvalid) begin
            r_bready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_resp  <= M_AXI_bresp;
            r_rsp_rdata <= '0;
            r_state     <= ST_IDLE;
          end
        end
        ST_RD_AR: begin
          if (M_AXI_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RD_R;
          end
        end
        ST_RD_R: begin
          if (M_AXI_rvalid) begin
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_resp  <= M_AXI_rresp;
            r_rsp_rdata <= M_AXI_rdata[DATA_WIDTH-1:0];
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
`ifdef AXI_TIMEOUT_EN
      r_timeout <= 1'b0;
      if (r_state == ST_IDLE) begin
        r_cnt <= '0;
      end else if (!w_complete && r_cnt == CNT_LIMIT) begin
        // Abort overrides the case above; a real completion this cycle still wins.
        r_awvalid   <= 1'b0;
        r_wvalid    <= 1'b0;
        r_bready    <= 1'b0;
        r_arvalid   <= 1'b0;
        r_rready    <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_resp  <= RESP_SLVERR;
        r_rsp_rdata <= '0;
        r_timeout   <= 1'b1;
        r_state     <= ST_IDLE;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
`endif
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;
  assign M_AXI_awaddr  = r_awaddr;
  assign M_AXI_awprot  = PROT_DEFAULT;
  assign M_AXI_awvalid = r_awvalid;
  assign M_AXI_wdata   = r_wdata;
  assign M_AXI_wstrb   = r_wstrb;
  assign M_AXI_wvalid  = r_wvalid;
  assign M_AXI_bready  = r_bready;
  assign M_AXI_araddr  = r_araddr;
  assign M_AXI_arprot  = PROT_DEFAULT;
  assign M_AXI_arvalid = r_arvalid;
  assign M_AXI_rready  = r_rready;

endmodule
